// File: rtl/pipe_wb_reg_pkg.sv
// rtl/pipe_wb_reg_pkg.sv - shared encodings and action decode for the MEM/WB register
package pipe_wb_reg_pkg;

    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } wb_action_e;

    // Flush beats everything; a stalled stage whose consumer is free emits a bubble.
    function automatic wb_action_e decode_action(input logic flush,
                                                 input logic own_stall,
                                                 input logic down_stall);
        if (flush)
            return ACT_BUBBLE;
        if (own_stall == STOP && down_stall == NO_STOP)
            return ACT_BUBBLE;
        if (own_stall == STOP)
            return ACT_HOLD;
        return ACT_LOAD;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_wb_reg.sv
// rtl/pipe_wb_reg.sv - multi-lane MEM/WB pipeline register with hold/bubble/flush control
module pipe_wb_reg
    import pipe_wb_reg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_LANES = 2,
    parameter int HILO_EN   = 1,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STALL_W-1:0]          stall,
    input  logic                        flush,
    input  logic [NUM_LANES-1:0]        mem_wreg,
    input  logic [NUM_LANES*ADDR_W-1:0] mem_wd,
    input  logic [NUM_LANES*DATA_W-1:0] mem_wdata,
    input  logic                        mem_whilo,
    input  logic [DATA_W-1:0]           mem_hi,
    input  logic [DATA_W-1:0]           mem_lo,
    output logic [NUM_LANES-1:0]        wb_wreg,
    output logic [NUM_LANES*ADDR_W-1:0] wb_wd,
    output logic [NUM_LANES*DATA_W-1:0] wb_wdata,
    output logic                        wb_whilo,
    output logic [DATA_W-1:0]           wb_hi,
    output logic [DATA_W-1:0]           wb_lo,
    output logic                        wb_valid,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            bubble_cnt,
    output logic [CNT_W-1:0]            hold_cnt
);

    wb_action_e action;
    logic       unused_stall;

    assign action       = decode_action(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);
    assign unused_stall = ^stall;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic              wreg_q,  wreg_d;
        logic [ADDR_W-1:0] wd_q,    wd_d;
        logic [DATA_W-1:0] wdata_q, wdata_d;

        always_comb begin
            wreg_d  = wreg_q;
            wd_d    = wd_q;
            wdata_d = wdata_q;
            case (action)
                ACT_LOAD: begin
                    wreg_d  = mem_wreg[i];
                    wd_d    = mem_wd[i*ADDR_W +: ADDR_W];
                    wdata_d = mem_wdata[i*DATA_W +: DATA_W];
                end
                ACT_BUBBLE: begin
                    wreg_d  = WRITE_DISABLE;
                    wd_d    = ADDR_W'(NOP_REG_ADDR);
                    wdata_d = DATA_W'(ZERO_WORD);
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wreg_q  <= WRITE_DISABLE;
                wd_q    <= '0;
                wdata_q <= '0;
            end else begin
                wreg_q  <= wreg_d;
                wd_q    <= wd_d;
                wdata_q <= wdata_d;
            end
        end

        assign wb_wreg[i]                    = wreg_q;
        assign wb_wd[i*ADDR_W +: ADDR_W]     = wd_q;
        assign wb_wdata[i*DATA_W +: DATA_W]  = wdata_q;
    end

    if (HILO_EN != 0) begin : g_hilo
        logic              whilo_q, whilo_d;
        logic [DATA_W-1:0] hi_q,    hi_d;
        logic [DATA_W-1:0] lo_q,    lo_d;

        always_comb begin
            whilo_d = whilo_q;
            hi_d    = hi_q;
            lo_d    = lo_q;
            case (action)
                ACT_LOAD: begin
                    whilo_d = mem_whilo;
                    hi_d    = mem_hi;
                    lo_d    = mem_lo;
                end
                ACT_BUBBLE: begin
                    whilo_d = WRITE_DISABLE;
                    hi_d    = DATA_W'(ZERO_WORD);
                    lo_d    = DATA_W'(ZERO_WORD);
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                whilo_q <= WRITE_DISABLE;
                hi_q    <= '0;
                lo_q    <= '0;
            end else begin
                whilo_q <= whilo_d;
                hi_q    <= hi_d;
                lo_q    <= lo_d;
            end
        end

        assign wb_whilo = whilo_q;
        assign wb_hi    = hi_q;
        assign wb_lo    = lo_q;
    end else begin : g_no_hilo
        logic unused_hilo;
        assign unused_hilo = ^{mem_whilo, mem_hi, mem_lo};
        assign wb_whilo    = WRITE_DISABLE;
        assign wb_hi       = '0;
        assign wb_lo       = '0;
    end

    logic valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        case (action)
            ACT_LOAD:   valid_d = 1'b1;
            ACT_BUBBLE: valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_q <= 1'b0;
        else
            valid_q <= valid_d;
    end

    assign wb_valid = valid_q;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (action == ACT_BUBBLE),
        .clr   (cnt_clr),
        .cnt   (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (action == ACT_HOLD),
        .clr   (cnt_clr),
        .cnt   (hold_cnt)
    );

    // Upstream must never stall the consumer while this stage is free.
    illegal_stall_a: assert property (@(posedge clk) disable iff (!rst)
        !((stall[STAGE_IDX] == NO_STOP) && (stall[STAGE_IDX+1] == STOP)));

endmodule

// File: tb/tb_pipe_wb_reg.sv
// tb/tb_pipe_wb_reg.sv - self-checking bench for pipe_wb_reg
module tb_pipe_wb_reg;

    localparam int SI  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush, cnt_clr;
    logic [1:0]  mem_wreg;
    logic [9:0]  mem_wd;
    logic [63:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;

    logic [1:0]    a_wreg, b_wreg;
    logic [9:0]    a_wd, b_wd;
    logic [63:0]   a_wdata, b_wdata;
    logic          a_whilo, b_whilo, a_valid, b_valid;
    logic [31:0]   a_hi, a_lo, b_hi, b_lo;
    logic [CW-1:0] a_bub, a_hold, b_bub, b_hold;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pipe_wb_reg #(.CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_wreg(a_wreg), .wb_wd(a_wd), .wb_wdata(a_wdata),
        .wb_whilo(a_whilo), .wb_hi(a_hi), .wb_lo(a_lo), .wb_valid(a_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(a_bub), .hold_cnt(a_hold)
    );

    pipe_wb_reg #(.CNT_W(CW), .HILO_EN(0)) u_nohilo (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_wreg(b_wreg), .wb_wd(b_wd), .wb_wdata(b_wdata),
        .wb_whilo(b_whilo), .wb_hi(b_hi), .wb_lo(b_lo), .wb_valid(b_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(b_bub), .hold_cnt(b_hold)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the stage must show after each edge, from the action rules.
    logic [1:0]  m_wreg;
    logic [9:0]  m_wd;
    logic [63:0] m_wdata;
    logic        m_whilo, m_valid;
    logic [31:0] m_hi, m_lo;
    int          m_bub, m_hold;
    bit          is_bub, is_hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wreg = 0; m_wd = 0; m_wdata = 0; m_whilo = 0; m_hi = 0; m_lo = 0;
            m_valid = 0; m_bub = 0; m_hold = 0;
        end else begin
            is_bub  = flush || (stall[SI] && !stall[SI+1]);
            is_hold = !flush && stall[SI] && stall[SI+1];
            if (is_bub) begin
                m_wreg = 0; m_wd = 0; m_wdata = 0; m_whilo = 0; m_hi = 0; m_lo = 0;
                m_valid = 0;
            end else if (!is_hold) begin
                m_wreg = mem_wreg; m_wd = mem_wd; m_wdata = mem_wdata;
                m_whilo = mem_whilo; m_hi = mem_hi; m_lo = mem_lo; m_valid = 1;
            end
            if (cnt_clr) begin
                m_bub = 0; m_hold = 0;
            end else begin
                if (is_bub)  m_bub  = (m_bub  < SAT) ? m_bub + 1  : SAT;
                if (is_hold) m_hold = (m_hold < SAT) ? m_hold + 1 : SAT;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wreg",   a_wreg,   m_wreg);
            chk("wd",     a_wd,     m_wd);
            chk("wdata",  a_wdata,  m_wdata);
            chk("whilo",  a_whilo,  m_whilo);
            chk("hi",     a_hi,     m_hi);
            chk("lo",     a_lo,     m_lo);
            chk("valid",  a_valid,  m_valid);
            chk("bubcnt", a_bub,    m_bub);
            chk("holdcnt", a_hold,  m_hold);
            chk("nh_wreg",  b_wreg,  m_wreg);
            chk("nh_wd",    b_wd,    m_wd);
            chk("nh_wdata", b_wdata, m_wdata);
            chk("nh_valid", b_valid, m_valid);
            chk("nh_hilo",  {b_whilo, b_hi, b_lo}, 0);
            chk("nh_cnts",  {b_bub, b_hold}, {m_bub[CW-1:0], m_hold[CW-1:0]});
        end
    end

    task automatic step(input logic [5:0] s, input logic f, input logic c);
        stall = s; flush = f; cnt_clr = c;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic rnd_mem();
        mem_wreg  = 2'($urandom);
        mem_wd    = 10'($urandom);
        mem_wdata = {$urandom, $urandom};
        mem_whilo = 1'($urandom);
        mem_hi    = $urandom;
        mem_lo    = $urandom;
    endtask

    initial begin
        rst = 1'b0; stall = 0; flush = 0; cnt_clr = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0; mem_whilo = 0; mem_hi = 0; mem_lo = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_wd", a_wd, 0);
        chk("rst_cnts", {a_bub, a_hold}, 0);
        cmp_en = 1'b1;
        rst = 1'b1;

        mem_wreg = 2'b01; mem_wd = 10'd5; mem_wdata = 64'h0000_0000_DEAD_BEEF;
        step(6'b000000, 0, 0);
        chk("lit_wd0", a_wd[4:0], 5);
        chk("lit_wdata0", a_wdata[31:0], 32'hDEADBEEF);
        chk("lit_valid", a_valid, 1);

        mem_wreg = 2'b11; mem_wd = {5'd31, 5'd5}; mem_wdata = 64'hA5A5_A5A5_DEAD_BEEF;
        mem_whilo = 1; mem_hi = 32'h1; mem_lo = 32'h2;
        step(6'b000000, 0, 0);
        chk("lit_hilo", {a_whilo, a_hi, a_lo}, {1'b1, 32'h1, 32'h2});
        chk("lit_wd1", a_wd[9:5], 31);
        chk("lit_wdata1", a_wdata[63:32], 32'hA5A5A5A5);
        chk("lit_nh_hi", b_hi, 0);

        for (int i = 0; i < 3; i++) begin
            rnd_mem();
            step(6'b110000, 0, 0);
        end
        chk("lit_hold_wd", a_wd, 10'h3E5);
        chk("lit_hold_data", a_wdata, 64'hA5A5_A5A5_DEAD_BEEF);
        chk("lit_hold_cnt", a_hold, 3);
        chk("lit_hold_bub", a_bub, 0);

        step(6'b010000, 0, 0);
        chk("lit_bub_out", {a_wreg, a_wd, a_whilo, a_valid}, 0);
        chk("lit_bub_cnt", a_bub, 1);

        rnd_mem();
        step(6'b000000, 0, 0);
        step(6'b110000, 1, 0);
        chk("lit_flush_valid", a_valid, 0);
        chk("lit_flush_cnts", {a_bub, a_hold}, {4'd2, 4'd3});

        for (int i = 0; i < 30; i++) begin
            logic [1:0] pat;
            rnd_mem();
            case ($urandom_range(0, 3))
                0, 1:    pat = 2'b00;
                2:       pat = 2'b01;
                default: pat = 2'b11;
            endcase
            step({pat, 4'($urandom)}, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        step(6'b000000, 0, 1);
        for (int i = 0; i < 20; i++) begin
            rnd_mem();
            step(6'b110000, 0, 0);
        end
        chk("lit_sat_hold", a_hold, 15);
        step(6'b110000, 0, 1);
        chk("lit_clr_hold", {a_bub, a_hold}, 0);

        mem_wreg = 2'b11; mem_wdata = 64'h1234_5678_9ABC_DEF0;
        step(6'b000000, 0, 0);
        chk("lit_pre_rst", a_valid, 1);
        step(6'b110000, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("lit_async_data", a_wdata, 0);
        chk("lit_async_valid", {a_valid, a_wreg}, 0);
        chk("lit_async_cnt", a_hold, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        step(6'b110000, 0, 0);
        chk("lit_post_hold", a_hold, 1);
        chk("lit_post_valid", a_valid, 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_wb_reg.md
Name: pipe_wb_reg

Overview:
Parametrised MEM/WB pipeline register, successor to the single-lane stage register. It carries NUM_LANES register-file write ports plus an optional HI/LO write port from the memory stage to write-back. It uses an explicit hold/bubble/flush priority scheme driven by the global stall vector, with a valid bit per lane. It also keeps saturating performance counters for bubble and hold cycles, read by the debug/CP0 path.

Parameters:
DATA_W, 32, register/HI/LO data width
ADDR_W, 5, register-file address width
NUM_LANES, 2, independent write-back lanes (1..4)
HILO_EN, 1, 1 = HI/LO port present; 0 = HI/LO outputs tied 0, no flops
STALL_W, 6, width of the global stall vector
STAGE_IDX, 4, bit of stall owned by this stage; STAGE_IDX+1 is the downstream bit; STAGE_IDX+1 < STALL_W
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  STALL_W  global stall vector, 1 = stop
flush  in  1  kill the instruction entering this stage (exception/eret)
mem_wreg  in  NUM_LANES  per-lane write enable
mem_wd  in  NUM_LANES*ADDR_W  per-lane dest address, lane i at [i*ADDR_W +: ADDR_W]
mem_wdata  in  NUM_LANES*DATA_W  per-lane write data
mem_whilo  in  1  HI/LO write enable
mem_hi  in  DATA_W  HI data
mem_lo  in  DATA_W  LO data
wb_wreg  out  NUM_LANES  registered write enables
wb_wd  out  NUM_LANES*ADDR_W  registered addresses
wb_wdata  out  NUM_LANES*DATA_W  registered data
wb_whilo  out  1  registered HI/LO enable
wb_hi  out  DATA_W  registered HI
wb_lo  out  DATA_W  registered LO
wb_valid  out  1  stage holds a real (non-bubble) instruction
cnt_clr  in  1  synchronous clear of both counters
bubble_cnt  out  CNT_W  cycles a bubble was inserted
hold_cnt  out  CNT_W  cycles the stage held

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, including wb_valid, wb_wd (NOP address 0), both counters, wb_hi and wb_lo. Release is synchronous to clk via the existing reset synchroniser.
- Per-edge action, in priority order:
  1. flush=1 -> BUBBLE. flush overrides stall.
  2. stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0 -> BUBBLE.
  3. stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1 -> HOLD.
  4. Otherwise -> LOAD.
- BUBBLE: wb_wreg=0, wb_wd=0, wb_wdata=0, wb_whilo=0, wb_hi=0, wb_lo=0, wb_valid=0.
- HOLD: all wb_* registers and wb_valid keep their values. This must be a true hold; the stage must not reload from mem_*.
- LOAD: all wb_* take the mem_* values; wb_valid=1.
- Latency is exactly 1 cycle in LOAD. The stage has no combinational path from inputs to outputs.
- Lanes are independent in data but share the action. No cross-lane priority: lanes writing the same address are resolved in the register file (higher lane wins).
- HILO_EN=0: wb_whilo, wb_hi, wb_lo are constant 0 and mem_hi/mem_lo/mem_whilo are ignored.
- Counters:
  - bubble_cnt increments on each BUBBLE edge.
  - hold_cnt increments on each HOLD edge.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr=1 forces both to 0 on that edge and takes priority over increment.
- stall[STAGE_IDX]=0 with stall[STAGE_IDX+1]=1 is illegal upstream. The stage treats it as LOAD, and an assertion flags it in simulation.
- Reset asserted mid-HOLD or mid-BUBBLE clears state immediately. The first edge after release follows the normal priority order.

Decomposition:
- Shared package/define file: stall encodings (Stop=1, NoStop=0), NOP register address, WriteEnable/WriteDisable, ZeroWord.
- Add a localparam enum for the action: LOAD, HOLD, BUBBLE.
- One natural sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.
- Lane registers are built with a generate loop. No other sub-modules.

Test Plan:
- Reset then LOAD: rst 0->1, lane0 wreg=1 wd=5 wdata=0xDEADBEEF, stall=0 -> next cycle wb_wd[0]=5, wb_wdata[0]=0xDEADBEEF, wb_valid=1.
- Hold: stall=6'b110000 for 3 cycles with mem_* changing each cycle -> wb_* unchanged; hold_cnt=3; bubble_cnt=0.
- Bubble: stall=6'b010000 for 1 cycle -> wb_wreg=0, wb_wd=0, wb_whilo=0, wb_valid=0; bubble_cnt=1.
- Flush over stall: flush=1 with stall=6'b110000 -> BUBBLE applied, not HOLD; bubble_cnt increments, hold_cnt does not.
- HI/LO and multi-lane: whilo=1, hi=0x1, lo=0x2, lane1 wd=31 wdata=0xA5A5A5A5, stall=0 -> all registered in 1 cycle. With HILO_EN=0 build -> wb_hi=wb_lo=0 always.
- Counter saturation and clear: CNT_W=4, 20 HOLD cycles -> hold_cnt=15; cnt_clr with simultaneous HOLD -> 0. Async reset mid-hold -> outputs 0 before the next edge.
